// File: rtl/ippcrc_pkg.sv
// Shared CRC-32 constants, scheduler FSM states and the reflected byte-step function.
// The 8b and 112b datapaths both use crc32_byte, so their bit ordering is identical.
package ippcrc_pkg;

  localparam int          CRC32_WORD_BYTES = 14;
  localparam logic [31:0] CRC32_RESIDUE    = 32'hDEBB_20E3;
  localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAIL = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // LSB-first (reflected) Ethernet CRC-32: one byte, bit 0 of the byte goes first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ippcrc_crc32_112b.sv
// Combinational 14-byte CRC-32 step; data[111:104] is the first byte on the wire.
module ippcrc_crc32_112b
  import ippcrc_pkg::*;
(
  input  logic [31:0]  seed,
  input  logic [111:0] data,
  output logic [31:0]  crc_next
);

  always_comb begin
    crc_next = seed;
    for (int k = 0; k < CRC32_WORD_BYTES; k++) begin
      crc_next = crc32_byte(crc_next, data[111-8*k -: 8]);
    end
  end

endmodule

// File: rtl/ippcrc_crc32_8b.sv
// Combinational single-byte CRC-32 step used to fold in short final words.
module ippcrc_crc32_8b
  import ippcrc_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  assign crc_next = crc32_byte(crc, data);

endmodule

// File: rtl/ippcrc_crc32_sched.sv
// Round-robin CRC-32 scheduler: NCH channels share one 112b core; short eop words drain bytewise.
// Residue check on eop is built only when IPPCRC_SCHED_CHECK_EN is defined.
module ippcrc_crc32_sched
  import ippcrc_pkg::*;
#(
  parameter int          NCH        = 4,
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req_vld,
  input  logic [NCH-1:0]     req_sop,
  input  logic [NCH-1:0]     req_eop,
  input  logic [4*NCH-1:0]   req_nbyte,
  input  logic [112*NCH-1:0] req_data,
  output logic [NCH-1:0]     req_rdy,
  output logic               crc_vld,
  output logic [2:0]         crc_ch,
  output logic [31:0]        crc_val,
  output logic               crc_err
);

  sched_state_t state, state_nxt;
  logic [31:0]  crc_q [NCH];
  logic [2:0]   ptr, gnt, cur_ch;
  logic         grant;
  logic         sel_sop, sel_eop, sel_full;
  logic [3:0]   sel_nb;
  logic [111:0] sel_data;
  logic [31:0]  sel_crc, seed, core_crc, byte_crc, done_crc;
  logic [31:0]  tail_crc;
  logic [111:0] tail_data;
  logic [3:0]   tail_nb, tail_k;
  logic         tail_last;

  // Lowest requester at or after ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    gnt = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (req_vld[i]) gnt = 3'(i);
    end
    for (int i = NCH-1; i >= 0; i--) begin
      if (req_vld[i] && (3'(i) >= ptr)) gnt = 3'(i);
    end
  end

  assign grant   = (|req_vld) && (state != TAIL);
  assign req_rdy = grant ? (NCH'(1) << gnt) : '0;

  always_comb begin
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    sel_nb   = '0;
    sel_data = '0;
    sel_crc  = '0;
    done_crc = '0;
    for (int i = 0; i < NCH; i++) begin
      if (3'(i) == gnt) begin
        sel_sop  = req_sop[i];
        sel_eop  = req_eop[i];
        sel_nb   = req_nbyte[4*i +: 4];
        sel_data = req_data[112*i +: 112];
        sel_crc  = crc_q[i];
      end
      if (3'(i) == cur_ch) done_crc = crc_q[i];
    end
  end

  // nbyte of 0 or 15 on eop is treated as a full word.
  assign sel_full  = !sel_eop || (sel_nb == 4'd0) || (sel_nb >= 4'(CRC32_WORD_BYTES));
  assign seed      = sel_sop ? CRC_INIT : sel_crc;
  assign tail_last = (tail_k == tail_nb - 4'd1);

  ippcrc_crc32_112b u_core (.seed(seed), .data(sel_data), .crc_next(core_crc));
  ippcrc_crc32_8b   u_byte (.crc(tail_crc), .data(tail_data[111:104]), .crc_next(byte_crc));

  always_comb begin
    state_nxt = state;
    crc_vld   = 1'b0;
    crc_ch    = '0;
    crc_val   = '0;
    crc_err   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (grant && sel_eop) state_nxt = sel_full ? DONE : TAIL;
        else                  state_nxt = IDLE;
      end
      TAIL:    if (tail_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (state == DONE) begin
      crc_vld = 1'b1;
      crc_ch  = cur_ch;
      crc_val = done_crc ^ CRC_XOROUT;
`ifdef IPPCRC_SCHED_CHECK_EN
      crc_err = (done_crc != CRC32_RESIDUE);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_ch    <= '0;
      tail_crc  <= '0;
      tail_data <= '0;
      tail_nb   <= '0;
      tail_k    <= '0;
      for (int i = 0; i < NCH; i++) crc_q[i] <= CRC_INIT;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr    <= (gnt == 3'(NCH-1)) ? 3'd0 : gnt + 3'd1;
        cur_ch <= gnt;
      end
      if (grant && !sel_full) begin
        tail_crc  <= seed;
        tail_data <= sel_data;
        tail_nb   <= sel_nb;
        tail_k    <= '0;
      end
      // Tail bytes are consumed from the top of the shift register, first wire byte first.
      if (state == TAIL) begin
        tail_crc  <= byte_crc;
        tail_data <= tail_data << 8;
        tail_k    <= tail_k + 4'd1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (grant && sel_full && (3'(i) == gnt))
          crc_q[i] <= core_crc;
        else if ((state == TAIL) && tail_last && (3'(i) == cur_ch))
          crc_q[i] <= byte_crc;
      end
    end
  end

endmodule

// File: tb/tb_ippcrc_crc32_sched.sv
// Directed bench for ippcrc_crc32_sched with a byte-queue CRC model and a per-cycle compare process.
module tb_ippcrc_crc32_sched;

  localparam int NCH = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NCH-1:0]     req_vld = '0, req_sop = '0, req_eop = '0;
  logic [4*NCH-1:0]   req_nbyte = '0;
  logic [112*NCH-1:0] req_data = '0;
  logic [NCH-1:0]     req_rdy;
  logic               crc_vld, crc_err;
  logic [2:0]         crc_ch;
  logic [31:0]        crc_val;

  ippcrc_crc32_sched #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_sop(req_sop), .req_eop(req_eop),
    .req_nbyte(req_nbyte), .req_data(req_data), .req_rdy(req_rdy), .crc_vld(crc_vld),
    .crc_ch(crc_ch), .crc_val(crc_val), .crc_err(crc_err)
  );

  always #5 clk = ~clk;

  // Stand-alone datapath pair: one 112b step against fourteen chained byte steps.
  logic [31:0]  eq_seed, eq_core;
  logic [31:0]  eq_chain [15];
  logic [111:0] eq_data;
  ippcrc_crc32_112b u_eq_core (.seed(eq_seed), .data(eq_data), .crc_next(eq_core));
  assign eq_chain[0] = eq_seed;
  for (genvar k = 0; k < 14; k++) begin : g_chain
    ippcrc_crc32_8b u_step (.crc(eq_chain[k]), .data(eq_data[111-8*k -: 8]), .crc_next(eq_chain[k+1]));
  end

  typedef struct {
    logic         sop;
    logic         eop;
    logic [3:0]   nb;
    logic [111:0] data;
  } word_t;

  typedef struct {
    int          due;
    int          ch;
    logic [31:0] val;
    logic        err;
  } exp_t;

  word_t      chq [NCH][$];
  exp_t       expq[$];
  logic [7:0] pkt [NCH][$];

  int total = 0, bad = 0, cyc = 0;
  int ptr_m = 0, busy_until = -1;
  int n_results = 0, last_vld_cyc = 0, last_ch = 0;
  logic [31:0] last_val = '0;
  logic        last_err = 1'b0;
  int last_acc_cyc [NCH];
  int gnt_count = 0, first_gnt = 0, last_gnt = 0;
  int gnt_log[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference CRC: bit-serial over the whole packet byte list, LSB of each byte first.
  function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return c;
  endfunction

  function automatic word_t mk(input logic sop, input logic eop, input logic [3:0] nb, input logic [111:0] d);
    word_t w;
    w.sop = sop; w.eop = eop; w.nb = nb; w.data = d;
    return w;
  endfunction

  function automatic logic [111:0] rand112();
    logic [111:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) d = (d << 32) | 112'($urandom());
    return d;
  endfunction

  task automatic accept(input int ch);
    word_t w;
    int    n;
    logic  full;
    logic [31:0] c;
    exp_t  e;
    w = chq[ch].pop_front();
    if (gnt_count == 0) first_gnt = cyc;
    gnt_count++;
    last_gnt = cyc;
    gnt_log.push_back(ch);
    last_acc_cyc[ch] = cyc;
    ptr_m = (ch + 1) % NCH;
    if (w.sop) pkt[ch].delete();
    full = !w.eop || (w.nb == 0) || (w.nb >= 14);
    n = full ? 14 : int'(w.nb);
    for (int k = 0; k < n; k++) pkt[ch].push_back(w.data[111-8*k -: 8]);
    if (w.eop) begin
      c = crc_of(pkt[ch]);
      e.due = cyc + (full ? 1 : n + 1);
      e.ch  = ch;
      e.val = c ^ 32'hFFFF_FFFF;
`ifdef IPPCRC_SCHED_CHECK_EN
      e.err = (c != 32'hDEBB_20E3);
`else
      e.err = 1'b0;
`endif
      expq.push_back(e);
      if (!full) busy_until = cyc + n;
    end
  endtask

  // Single compare process: arbitration, result strobe and result contents every cycle.
  logic [NCH-1:0] exp_rdy;
  int hit, idx;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      expq.delete();
      for (int ch = 0; ch < NCH; ch++) pkt[ch].delete();
      ptr_m = 0;
      busy_until = -1;
      check("reset_crc_vld", {31'h0, crc_vld}, 32'h0);
      check("reset_crc_val", crc_val, 32'h0);
    end else begin
      exp_rdy = '0;
      if (cyc > busy_until) begin
        for (int i = NCH-1; i >= 0; i--) begin
          idx = (ptr_m + i) % NCH;
          if (req_vld[idx]) exp_rdy = NCH'(1) << idx;
        end
      end
      check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
      hit = -1;
      foreach (expq[i]) if (expq[i].due == cyc) hit = i;
      check("crc_vld", {31'h0, crc_vld}, {31'h0, hit >= 0});
      if (hit >= 0) begin
        check("crc_ch", 32'(crc_ch), 32'(expq[hit].ch));
        check("crc_val", crc_val, expq[hit].val);
        check("crc_err", {31'h0, crc_err}, {31'h0, expq[hit].err});
        expq.delete(hit);
      end
      if (crc_vld) begin
        n_results++;
        last_vld_cyc = cyc;
        last_ch = int'(crc_ch);
        last_val = crc_val;
        last_err = crc_err;
      end
      for (int ch = 0; ch < NCH; ch++)
        if (req_vld[ch] && req_rdy[ch] && chq[ch].size() > 0) accept(ch);
    end
  end

  // Driver: presents the head of each channel queue, held until accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
        if (chq[ch].size() > 0) begin
          req_vld[ch] = 1'b1;
          req_sop[ch] = chq[ch][0].sop;
          req_eop[ch] = chq[ch][0].eop;
          req_nbyte[4*ch +: 4] = chq[ch][0].nb;
          req_data[112*ch +: 112] = chq[ch][0].data;
        end else begin
          req_vld[ch] = 1'b0;
          req_sop[ch] = 1'b0;
          req_eop[ch] = 1'b0;
        end
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int ch = 0; ch < NCH; ch++) chq[ch].delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    logic busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 2000) begin
      @(posedge clk);
      n++;
      busy = (expq.size() > 0);
      for (int ch = 0; ch < NCH; ch++) if (chq[ch].size() > 0) busy = 1'b1;
    end
    check("drain_timeout", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  localparam logic [71:0]  S123 = "123456789";
  logic [7:0]   tq[$];
  logic [111:0] d, fcs_word;
  int           n0, w;

  initial begin
    // Model pins: standard check value and residue.
    for (int k = 0; k < 9; k++) tq.push_back(S123[71-8*k -: 8]);
    check("model_check_value", crc_of(tq) ^ 32'hFFFF_FFFF, 32'hCBF4_3926);
    tq.push_back(8'h26); tq.push_back(8'h39); tq.push_back(8'hF4); tq.push_back(8'hCB);
    check("model_residue", crc_of(tq), 32'hDEBB_20E3);

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 1: "123456789" as a 9-byte tail on ch0.
    chq[0].push_back(mk(1'b1, 1'b1, 4'd9, {S123, 40'h0}));
    drain();
    check("t1_crc_val", last_val, 32'hCBF4_3926);
    check("t1_crc_ch", 32'(last_ch), 32'd0);
    check("t1_latency", 32'(last_vld_cyc - last_acc_cyc[0]), 32'd10);

    // 2: full-word path vs byte-serial chain, plus a full eop word through the DUT.
    for (int r = 0; r < 4; r++) begin
      eq_seed = $urandom();
      eq_data = rand112();
      #1;
      check("t2_core_vs_bytes", eq_core, eq_chain[14]);
    end
    chq[0].push_back(mk(1'b1, 1'b1, 4'd14, rand112()));
    drain();
    check("t2_full_latency", 32'(last_vld_cyc - last_acc_cyc[0]), 32'd1);

    // 3: all channels saturated -> strict 0,1,2,3 rotation with no idle cycles.
    pulse_reset();
    gnt_count = 0;
    gnt_log.delete();
    for (int ch = 0; ch < NCH; ch++) begin
      d = rand112();
      chq[ch].push_back(mk(1'b1, 1'b0, 4'd0, d));
      chq[ch].push_back(mk(1'b0, 1'b0, 4'd3, ~d));
      chq[ch].push_back(mk(1'b0, 1'b0, 4'd0, rand112()));
      chq[ch].push_back(mk(1'b0, 1'b1, 4'd14, rand112()));
    end
    drain();
    check("t3_grants", 32'(gnt_count), 32'd16);
    check("t3_no_gaps", 32'(last_gnt - first_gnt), 32'd15);
    for (int i = 0; i < 16; i++) check("t3_order", 32'(gnt_log[i]), 32'(i % 4));

    // 4: ch1/ch2 interleaved, ch2 sop mid-ch1; ch3 restarts with a second sop; nbyte 0 and 15.
    n0 = n_results;
    chq[1].push_back(mk(1'b1, 1'b0, 4'd0, rand112()));
    chq[1].push_back(mk(1'b0, 1'b0, 4'd0, rand112()));
    chq[1].push_back(mk(1'b0, 1'b1, 4'd5, rand112()));
    w = 0;
    while (chq[1].size() > 2 && w < 100) begin @(posedge clk); w++; end
    chq[2].push_back(mk(1'b1, 1'b0, 4'd0, rand112()));
    chq[2].push_back(mk(1'b0, 1'b0, 4'd0, rand112()));
    chq[2].push_back(mk(1'b0, 1'b1, 4'd0, rand112()));
    chq[3].push_back(mk(1'b1, 1'b0, 4'd0, rand112()));
    chq[3].push_back(mk(1'b1, 1'b0, 4'd0, rand112()));
    chq[3].push_back(mk(1'b0, 1'b1, 4'd15, rand112()));
    drain();
    check("t4_results", 32'(n_results - n0), 32'd3);

    // 5: reset in the middle of a 13-byte tail; no result, then a clean packet.
    chq[0].push_back(mk(1'b1, 1'b1, 4'd13, rand112()));
    w = 0;
    while (chq[0].size() > 0 && w < 100) begin @(posedge clk); w++; end
    repeat (4) @(posedge clk);
    n0 = n_results;
    pulse_reset();
    repeat (20) @(posedge clk);
    check("t5_no_result", 32'(n_results - n0), 32'd0);
    chq[0].push_back(mk(1'b1, 1'b0, 4'd0, rand112()));
    chq[0].push_back(mk(1'b0, 1'b1, 4'd13, rand112()));
    drain();
    check("t5_after_reset", 32'(n_results - n0), 32'd1);

    // 6: residue check with good and corrupted FCS packets on ch2.
    fcs_word = {S123, 8'h26, 8'h39, 8'hF4, 8'hCB, 8'h00};
    chq[2].push_back(mk(1'b1, 1'b1, 4'd13, fcs_word));
    drain();
    check("t6_good_err", {31'h0, last_err}, 32'h0);
    check("t6_good_val", last_val, 32'hDEBB_20E3 ^ 32'hFFFF_FFFF);
    fcs_word[104] = ~fcs_word[104];
    chq[2].push_back(mk(1'b1, 1'b1, 4'd13, fcs_word));
    drain();
`ifdef IPPCRC_SCHED_CHECK_EN
    check("t6_bad_err", {31'h0, last_err}, 32'h1);
`else
    check("t6_bad_err", {31'h0, last_err}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ippcrc_crc32_sched.md
Name: ippcrc_crc32_sched

Overview:
- Multi-channel CRC-32 scheduler. NCH packet streams share one 112-bit-per-cycle CRC-32 core (ippcrc_crc32_112b) through a round-robin arbiter.
- Keeps a running CRC per channel. Full 14-byte words go through the 112b core in one cycle. A short final word is folded in one byte per cycle through a byte-step sub-module.
- Sits between the packet-assembly front end and the FCS insert/check stage.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- CRC_INIT, 32'hFFFF_FFFF, per-packet seed loaded on sop.
- CRC_XOROUT, 32'hFFFF_FFFF, XOR applied to the reported result.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NCH  per-channel word valid
- req_sop  in  NCH  word is first of packet
- req_eop  in  NCH  word is last of packet
- req_nbyte  in  4*NCH  valid bytes in eop word (1..14); ignored without eop
- req_data  in  112*NCH  word data; [111:104] is first byte on wire
- req_rdy  out  NCH  word accepted this cycle (one-hot or zero)
- crc_vld  out  1  result strobe, 1 cycle
- crc_ch  out  3  channel of result
- crc_val  out  32  final CRC (running CRC ^ CRC_XOROUT)
- crc_err  out  1  residue check failure (see Optional Feature)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values: all outputs 0; per-channel CRC = CRC_INIT; round-robin pointer = 0; FSM = IDLE.
- FSM states: IDLE, TAIL, DONE.
- IDLE:
  - Arbiter grants the lowest-index requesting channel at or after ptr. It asserts req_rdy[g] combinationally in the same cycle.
  - ptr <= g+1 mod NCH on every grant.
  - Seed = CRC_INIT if req_sop, else crc[g].
  - Non-eop word, or eop with nbyte = 14: crc[g] <= core(seed, data) at the next edge.
  - Full eop word: next state DONE.
  - eop with nbyte < 14: latch seed, data, nbyte and g; next state TAIL.
- TAIL:
  - One byte per cycle, byte k from [111-8k -: 8], k = 0..nbyte-1.
  - No grants while in TAIL; req_rdy = 0.
  - After the last byte, store crc[g]; next state DONE.
- DONE:
  - crc_vld = 1 for one cycle, with crc_ch = g and crc_val = crc[g] ^ CRC_XOROUT.
  - The arbiter may grant in the same cycle; DONE behaves as IDLE for arbitration.
- Latency:
  - Full eop word accepted at cycle T gives crc_vld at T+1.
  - Tail of n bytes accepted at T gives crc_vld at T+n+1.
- Throughput: one full word per cycle, aggregate across channels.
- Boundary conditions:
  - sop and eop together: single-word packet seeded with CRC_INIT.
  - sop mid-packet: silently restarts that channel with CRC_INIT.
  - nbyte 0 or 15 on eop: treated as 14.
  - req_vld without req_rdy: the requester holds data stable. Non-granted channels are not disturbed.
  - Channel CRCs are independent; interleaved words across channels never cross-contaminate.
  - rst_n low mid-TAIL: the tail is abandoned, no crc_vld is produced, all state is reinitialised.

Optional Feature:
- Macro IPPCRC_SCHED_CHECK_EN.
- Defined: on eop, the unXORed running CRC, including the received FCS bytes, is compared to residue 32'hDEBB_20E3. crc_err = 1 alongside crc_vld on mismatch.
- Undefined: crc_err tied 0; no comparator logic.

Decomposition:
- Shared package ippcrc_pkg holds:
  - CRC32_WORD_BYTES = 14
  - CRC32_RESIDUE = 32'hDEBB_20E3
  - the FSM state enum
- Sub-module ippcrc_crc32_8b: 32-bit CRC in, 8-bit data in, 32-bit CRC out, combinational.
  - Bit-ordering must match ippcrc_crc32_112b: 14 serial byte steps equal one 112b step.
- Instantiate one ippcrc_crc32_112b and one ippcrc_crc32_8b.

Test Plan:
1. Ch0 single word, sop+eop, nbyte=9, data "123456789" left-justified -> crc_vld at T+10, crc_ch=0, crc_val=32'hCBF4_3926.
2. Equivalence: random 14-byte word sent as full eop word vs. as a 14-byte serial tail (forced path) -> identical crc_val.
3. All 4 channels hold req_vld continuously -> grants 0,1,2,3,0,...; each channel gets exactly 1 of every 4 cycles; no gaps.
4. Ch1 and ch2 interleave 3-word packets, with ch2 sop arriving mid-ch1 packet -> both crc_val match the golden model independently.
5. rst_n pulsed low during the TAIL of a 13-byte eop -> no crc_vld; next packet on that channel yields a correct CRC.
6. With IPPCRC_SCHED_CHECK_EN: "123456789" + FCS bytes 26 39 F4 CB (nbyte=13) -> crc_err=0; flip one data bit -> crc_err=1.
